// File: rtl/cursor_pkt_uart_tx.sv
// Buffered cursor-report UART transmitter: queues button/axis reports in a FIFO,
// frames each as header/[seq]/buttons/axes/checksum and sends 8N1 or 8N2, LSB first.
module cursor_pkt_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned N_AXES       = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [7:0]  HEADER       = 8'hAA,
  parameter int unsigned CSUM_MODE    = 0,
  parameter int unsigned SEQ_EN       = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [7:0]                  in_buttons,
  input  logic [8*N_AXES-1:0]         in_delta,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  seq
);
  localparam int unsigned L  = 3 + SEQ_EN + N_AXES;
  localparam int unsigned EW = 8 * (N_AXES + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(L);
  localparam logic [AW:0]   DEPTH     = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(L - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state, w_state_nxt;
  logic [EW-1:0]   r_fifo [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [AW:0]     r_count;
  logic [7:0]      r_seq;
  logic [8*L-1:0]  r_pkt;
  logic [CW-1:0]   r_clk_cnt;
  logic [2:0]      r_bit_idx;
  logic [BW-1:0]   r_byte_idx;

  logic            w_push, w_pop, w_bit_end, w_pkt_done;
  logic [7:0]      w_pop_seq, w_csum;
  logic [EW-1:0]   w_entry;
  logic [8*L-1:0]  w_pkt;

  assign in_ready   = (r_count < DEPTH);
  assign w_push     = in_valid && in_ready;
  assign w_bit_end  = (r_clk_cnt == BIT_LAST);
  assign busy       = (r_state != S_IDLE);
  assign fifo_level = r_count;
  assign seq        = r_seq;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_pkt_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: if (w_bit_end) w_state_nxt = S_DATA;
      S_DATA:  if (w_bit_end && r_bit_idx == 3'd7) w_state_nxt = S_STOP;
      S_STOP: begin
        if (w_bit_end && r_bit_idx == STOP_LAST) begin
          if (r_byte_idx == BYTE_LAST) begin
            w_pkt_done = 1'b1;
            if (r_count != '0) begin
              w_pop       = 1'b1;
              w_state_nxt = S_START;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_state_nxt = S_START;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A pop that coincides with packet completion must carry the incremented seq.
  assign w_pop_seq = w_pkt_done ? r_seq + 8'd1 : r_seq;

  // Packet image, byte 0 in the low bits so a right shift yields LSB-first order.
  always_comb begin
    w_entry = r_fifo[r_rd_ptr];
    w_csum  = (SEQ_EN != 0) ? w_pop_seq : 8'h00;
    for (int unsigned i = 0; i <= N_AXES; i++)
      w_csum = (CSUM_MODE != 0) ? w_csum + w_entry[8*i +: 8] : w_csum ^ w_entry[8*i +: 8];
    w_pkt                            = '0;
    w_pkt[7:0]                       = HEADER;
    w_pkt[15:8]                      = w_pop_seq;
    w_pkt[8*(1+SEQ_EN) +: 8]         = w_entry[EW-1 -: 8];
    w_pkt[8*(2+SEQ_EN) +: 8*N_AXES]  = w_entry[8*N_AXES-1:0];
    w_pkt[8*L-1 -: 8]                = w_csum;
  end

  always_comb begin
    tx = 1'b1;
    case (r_state)
      S_START: tx = 1'b0;
      S_DATA:  tx = r_pkt[0];
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= {in_buttons, in_delta};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_seq      <= '0;
      r_pkt      <= '1;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
      if (w_pkt_done) r_seq <= r_seq + 8'd1;
      if (r_state == S_IDLE || w_bit_end) r_clk_cnt <= '0;
      else                                r_clk_cnt <= r_clk_cnt + CW'(1);
      if (w_pop) begin
        r_pkt      <= w_pkt;
        r_byte_idx <= '0;
      end
      // r_bit_idx counts data bits in DATA (wrapping 7->0) and stop bits in STOP.
      if (w_bit_end && r_state == S_DATA) begin
        r_pkt     <= r_pkt >> 1;
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (w_bit_end && r_state == S_STOP) begin
        if (r_bit_idx == STOP_LAST) begin
          r_bit_idx <= '0;
          if (r_byte_idx != BYTE_LAST) r_byte_idx <= r_byte_idx + BW'(1);
        end else begin
          r_bit_idx <= r_bit_idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cursor_pkt_uart_tx.sv
// Bench for cursor_pkt_uart_tx: three parameterisations, UART decoding monitors
// feeding a receive queue that is checked against an expected-byte scoreboard.
module tb_cursor_pkt_uart_tx;
  localparam int unsigned CPB = 4;

  typedef struct { int unsigned id; logic [7:0] data; } exp_t;
  typedef struct { int unsigned id; logic [7:0] data; logic ok; int unsigned t; } rx_t;

  logic        clk;
  logic [2:0]  rstv, vld;
  logic [7:0]  btn;
  logic [23:0] dlt;
  logic        rdy0, rdy1, rdy2, tx0, tx1, tx2, bsy0, bsy1, bsy2;
  logic [2:0]  lvl0, lvl1, lvl2;
  logic [7:0]  seq0, seq1, seq2;
  logic [2:0]  txv;
  exp_t        expq[$];
  rx_t         rxq[$];
  int unsigned n_cmp, n_bad, cyc;
  logic [7:0]  mseq;

  assign txv = {tx2, tx1, tx0};

  cursor_pkt_uart_tx #(.CLKS_PER_BIT(CPB)) u_d0 (
    .clk(clk), .rst(rstv[0]), .in_valid(vld[0]), .in_ready(rdy0), .in_buttons(btn),
    .in_delta(dlt[15:0]), .tx(tx0), .busy(bsy0), .fifo_level(lvl0), .seq(seq0));
  cursor_pkt_uart_tx #(.CLKS_PER_BIT(CPB), .CSUM_MODE(1), .SEQ_EN(0)) u_d1 (
    .clk(clk), .rst(rstv[1]), .in_valid(vld[1]), .in_ready(rdy1), .in_buttons(btn),
    .in_delta(dlt[15:0]), .tx(tx1), .busy(bsy1), .fifo_level(lvl1), .seq(seq1));
  cursor_pkt_uart_tx #(.CLKS_PER_BIT(CPB), .N_AXES(3), .STOP_BITS(2)) u_d2 (
    .clk(clk), .rst(rstv[2]), .in_valid(vld[2]), .in_ready(rdy2), .in_buttons(btn),
    .in_delta(dlt), .tx(tx2), .busy(bsy2), .fifo_level(lvl2), .seq(seq2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, got still running want finished");
    $fatal(1, "watchdog");
  end

  // Decodes one frame per falling start edge; every bit must hold for exactly CPB samples.
  task automatic mon(input int unsigned id, input int unsigned sb);
    logic [7:0] d;
    logic ok, s;
    int unsigned t0;
    forever begin
      @(negedge clk);
      if (txv[id[1:0]] === 1'b0) begin
        t0 = cyc; ok = 1'b1; d = '0; s = 1'b0;
        for (int unsigned b = 0; b < 9 + sb; b++) begin
          for (int unsigned c = 0; c < CPB; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (c == 0) s = txv[id[1:0]];
            else if (txv[id[1:0]] !== s) ok = 1'b0;
          end
          if (b == 0 && s !== 1'b0) ok = 1'b0;
          if (b >= 1 && b <= 8) d[3'(b - 1)] = s;
          if (b > 8 && s !== 1'b1) ok = 1'b0;
        end
        begin
          rx_t r;
          r.id = id; r.data = d; r.ok = ok; r.t = t0;
          rxq.push_back(r);
        end
      end
    end
  endtask

  task automatic ex(input int unsigned id, input logic [7:0] b);
    exp_t e;
    e.id = id; e.data = b;
    expq.push_back(e);
  endtask

  task automatic exp_pkt(input int unsigned id, input bit seq_en, input bit sum,
                         input int unsigned na, input logic [7:0] sq,
                         input logic [7:0] bt, input logic [23:0] dl);
    logic [7:0] c, a;
    c = 8'h00;
    ex(id, 8'hAA);
    if (seq_en) begin ex(id, sq); c = sq; end
    ex(id, bt);
    c = sum ? c + bt : c ^ bt;
    for (int unsigned i = 0; i < na; i++) begin
      a = dl[i*8 +: 8];
      ex(id, a);
      c = sum ? c + a : c ^ a;
    end
    ex(id, c);
  endtask

  task automatic test_reset();
    rstv = '1; vld = '0; btn = '0; dlt = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (tx0 !== 1'b1)  begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx0); end
    n_cmp++; if (bsy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bsy0); end
    n_cmp++; if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", rdy0); end
    n_cmp++; if (lvl0 !== 3'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", lvl0); end
    n_cmp++; if (seq0 !== 8'd0) begin n_bad++; $display("FAIL reset_seq: got %0d want 0", seq0); end
    n_cmp++; if ({tx1, tx2, bsy1, bsy2, rdy1, rdy2} !== 6'b110011 || {lvl1, lvl2, seq1, seq2} !== 22'd0) begin
      n_bad++; $display("FAIL reset_others: got %b %h want 110011 0", {tx1, tx2, bsy1, bsy2, rdy1, rdy2}, {lvl1, lvl2, seq1, seq2});
    end
    rstv = '0;
  endtask

  task automatic test_basic();
    logic [7:0] k [6];
    int unsigned n, ne, pt;
    rx_t r; exp_t e;
    k = '{8'hAA, 8'h00, 8'h01, 8'h05, 8'hFD, 8'hF9};
    for (int unsigned i = 0; i < 6; i++) ex(0, k[i]);
    btn = 8'h01; dlt = 24'h00FD05; vld[0] = 1'b1;
    @(posedge clk); #1; vld[0] = 1'b0;
    n_cmp++; if (lvl0 !== 3'd1 || bsy0 !== 1'b0 || tx0 !== 1'b1) begin
      n_bad++; $display("FAIL lat_edge_k: got level=%0d busy=%b tx=%b want 1 0 1", lvl0, bsy0, tx0);
    end
    @(posedge clk); #1;
    n_cmp++; if (lvl0 !== 3'd0 || bsy0 !== 1'b1 || tx0 !== 1'b0) begin
      n_bad++; $display("FAIL lat_edge_k1: got level=%0d busy=%b tx=%b want 0 1 0", lvl0, bsy0, tx0);
    end
    n = 0;
    while (bsy0 && n < 400) begin @(posedge clk); #1; n++; end
    n_cmp++; if (n != 240) begin n_bad++; $display("FAIL basic_pkt_time: got %0d want 240", n); end
    n_cmp++; if (seq0 !== 8'd1) begin n_bad++; $display("FAIL basic_seq: got %0d want 1", seq0); end
    ne = expq.size(); pt = 0;
    for (int unsigned i = 0; i < ne; i++) begin
      n_cmp++;
      if (rxq.size() == 0) begin n_bad++; $display("FAIL basic_rx: got no byte %0d want one", i); break; end
      r = rxq.pop_front(); e = expq.pop_front();
      if (r.id != e.id || r.data !== e.data || r.ok !== 1'b1 || (i > 0 && r.t != pt + 40)) begin
        n_bad++; $display("FAIL basic_byte%0d: got id%0d %h ok=%b gap=%0d want id%0d %h ok=1 gap=40", i, r.id, r.data, r.ok, r.t - pt, e.id, e.data);
      end
      pt = r.t;
    end
    expq.delete();
  endtask

  task automatic test_csum_noseq();
    logic [7:0] k [5];
    int unsigned n, ne, pt;
    rx_t r; exp_t e;
    k = '{8'hAA, 8'h01, 8'h05, 8'hFD, 8'h03};
    for (int unsigned i = 0; i < 5; i++) ex(1, k[i]);
    btn = 8'h01; dlt = 24'h00FD05; vld[1] = 1'b1;
    @(posedge clk); #1; vld[1] = 1'b0;
    @(posedge clk); #1;
    n = 0;
    while (bsy1 && n < 400) begin @(posedge clk); #1; n++; end
    n_cmp++; if (n != 200) begin n_bad++; $display("FAIL csum_pkt_time: got %0d want 200", n); end
    ne = expq.size(); pt = 0;
    for (int unsigned i = 0; i < ne; i++) begin
      n_cmp++;
      if (rxq.size() == 0) begin n_bad++; $display("FAIL csum_rx: got no byte %0d want one", i); break; end
      r = rxq.pop_front(); e = expq.pop_front();
      if (r.id != e.id || r.data !== e.data || r.ok !== 1'b1 || (i > 0 && r.t != pt + 40)) begin
        n_bad++; $display("FAIL csum_byte%0d: got id%0d %h ok=%b gap=%0d want id%0d %h ok=1 gap=40", i, r.id, r.data, r.ok, r.t - pt, e.id, e.data);
      end
      pt = r.t;
    end
    expq.delete();
  endtask

  task automatic test_axes_stop2();
    int unsigned n, ne, pt;
    rx_t r; exp_t e;
    btn = 8'($urandom); dlt = 24'($urandom);
    exp_pkt(2, 1'b1, 1'b0, 3, 8'd0, btn, dlt);
    vld[2] = 1'b1;
    @(posedge clk); #1; vld[2] = 1'b0;
    @(posedge clk); #1;
    n = 0;
    while (bsy2 && n < 600) begin @(posedge clk); #1; n++; end
    n_cmp++; if (n != 308) begin n_bad++; $display("FAIL axes_pkt_time: got %0d want 308", n); end
    n_cmp++; if (seq2 !== 8'd1) begin n_bad++; $display("FAIL axes_seq: got %0d want 1", seq2); end
    ne = expq.size(); pt = 0;
    for (int unsigned i = 0; i < ne; i++) begin
      n_cmp++;
      if (rxq.size() == 0) begin n_bad++; $display("FAIL axes_rx: got no byte %0d want one", i); break; end
      r = rxq.pop_front(); e = expq.pop_front();
      if (r.id != e.id || r.data !== e.data || r.ok !== 1'b1 || (i > 0 && r.t != pt + 44)) begin
        n_bad++; $display("FAIL axes_byte%0d: got id%0d %h ok=%b gap=%0d want id%0d %h ok=1 gap=44", i, r.id, r.data, r.ok, r.t - pt, e.id, e.data);
      end
      pt = r.t;
    end
    expq.delete();
  endtask

  task automatic test_back_to_back();
    logic [2:0] wl [5];
    logic       wr [5];
    int unsigned n, ne, pt;
    rx_t r; exp_t e;
    wl = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    wr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    rstv[0] = 1'b1; @(posedge clk); #1; rstv[0] = 1'b0; mseq = 8'd0;
    for (int unsigned i = 0; i < 5; i++) begin
      btn = 8'($urandom); dlt = 24'($urandom); vld[0] = 1'b1;
      exp_pkt(0, 1'b1, 1'b0, 2, mseq, btn, dlt); mseq++;
      @(posedge clk); #1;
      n_cmp++; if (lvl0 !== wl[i] || rdy0 !== wr[i]) begin
        n_bad++; $display("FAIL b2b_accept%0d: got level=%0d ready=%b want %0d %b", i, lvl0, rdy0, wl[i], wr[i]);
      end
    end
    for (int unsigned j = 0; j < 3; j++) begin
      btn = 8'hEE; dlt = 24'h123456; vld[0] = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (lvl0 !== 3'd4 || rdy0 !== 1'b0) begin
        n_bad++; $display("FAIL b2b_full%0d: got level=%0d ready=%b want 4 0", j, lvl0, rdy0);
      end
    end
    vld[0] = 1'b0;
    n = 0;
    while (bsy0 && n < 1500) begin @(posedge clk); #1; n++; end
    n_cmp++; if (n != 1194) begin n_bad++; $display("FAIL b2b_drain_time: got %0d want 1194", n); end
    n_cmp++; if (seq0 !== 8'd5) begin n_bad++; $display("FAIL b2b_seq: got %0d want 5", seq0); end
    ne = expq.size(); pt = 0;
    for (int unsigned i = 0; i < ne; i++) begin
      n_cmp++;
      if (rxq.size() == 0) begin n_bad++; $display("FAIL b2b_rx: got no byte %0d want one", i); break; end
      r = rxq.pop_front(); e = expq.pop_front();
      if (r.id != e.id || r.data !== e.data || r.ok !== 1'b1 || (i > 0 && r.t != pt + 40)) begin
        n_bad++; $display("FAIL b2b_byte%0d: got id%0d %h ok=%b gap=%0d want id%0d %h ok=1 gap=40", i, r.id, r.data, r.ok, r.t - pt, e.id, e.data);
      end
      pt = r.t;
    end
    n_cmp++; if (rxq.size() != 0) begin n_bad++; $display("FAIL b2b_extra: got %0d extra bytes want 0", rxq.size()); end
    expq.delete(); rxq.delete();
  endtask

  task automatic test_reset_mid();
    int unsigned n, ne, pt, lows;
    rx_t r; exp_t e;
    rstv[0] = 1'b1; @(posedge clk); #1; rstv[0] = 1'b0;
    btn = 8'h11; dlt = 24'h002233; vld[0] = 1'b1;
    @(posedge clk); #1;
    btn = 8'h44; dlt = 24'h005566;
    @(posedge clk); #1; vld[0] = 1'b0;
    n_cmp++; if (lvl0 !== 3'd1) begin n_bad++; $display("FAIL rmid_queued: got %0d want 1", lvl0); end
    repeat (94) @(posedge clk);
    #1; rstv[0] = 1'b1;
    @(posedge clk); #1; rstv[0] = 1'b0;
    n_cmp++; if (tx0 !== 1'b1 || lvl0 !== 3'd0 || seq0 !== 8'd0 || bsy0 !== 1'b0 || rdy0 !== 1'b1) begin
      n_bad++; $display("FAIL rmid_after: got tx=%b level=%0d seq=%0d busy=%b ready=%b want 1 0 0 0 1", tx0, lvl0, seq0, bsy0, rdy0);
    end
    lows = 0;
    for (int unsigned c = 0; c < 60; c++) begin @(posedge clk); #1; if (tx0 !== 1'b1) lows++; end
    n_cmp++; if (lows != 0) begin n_bad++; $display("FAIL rmid_idle: got %0d low cycles want 0", lows); end
    rxq.delete(); expq.delete();
    btn = 8'($urandom); dlt = 24'($urandom);
    exp_pkt(0, 1'b1, 1'b0, 2, 8'd0, btn, dlt);
    vld[0] = 1'b1;
    @(posedge clk); #1; vld[0] = 1'b0;
    n = 0;
    while (bsy0 || n == 0) begin @(posedge clk); #1; n++; if (n > 400) break; end
    n_cmp++; if (seq0 !== 8'd1) begin n_bad++; $display("FAIL rmid_seq: got %0d want 1", seq0); end
    ne = expq.size(); pt = 0;
    for (int unsigned i = 0; i < ne; i++) begin
      n_cmp++;
      if (rxq.size() == 0) begin n_bad++; $display("FAIL rmid_rx: got no byte %0d want one", i); break; end
      r = rxq.pop_front(); e = expq.pop_front();
      if (r.id != e.id || r.data !== e.data || r.ok !== 1'b1 || (i > 0 && r.t != pt + 40)) begin
        n_bad++; $display("FAIL rmid_byte%0d: got id%0d %h ok=%b gap=%0d want id%0d %h ok=1 gap=40", i, r.id, r.data, r.ok, r.t - pt, e.id, e.data);
      end
      pt = r.t;
    end
    expq.delete(); rxq.delete();
  endtask

  task automatic test_seq_wrap();
    int unsigned np, guard, n, ne, pt;
    logic acc;
    logic [7:0] wseq;
    rx_t r; exp_t e;
    rstv[0] = 1'b1; @(posedge clk); #1; rstv[0] = 1'b0; mseq = 8'd0;
    np = 0; guard = 0; wseq = 8'hFF;
    while (np < 257 && guard < 70000) begin
      btn = 8'($urandom); dlt = 24'($urandom); vld[0] = 1'b1;
      acc = rdy0;
      @(posedge clk); #1; guard++;
      if (acc) begin exp_pkt(0, 1'b1, 1'b0, 2, mseq, btn, dlt); mseq++; np++; end
    end
    vld[0] = 1'b0;
    n_cmp++; if (np != 257) begin n_bad++; $display("FAIL wrap_pushes: got %0d want 257", np); end
    n = 0;
    while (bsy0 && n < 2000) begin @(posedge clk); #1; n++; end
    n_cmp++; if (bsy0 !== 1'b0 || seq0 !== 8'd1) begin
      n_bad++; $display("FAIL wrap_end: got busy=%b seq=%0d want 0 1", bsy0, seq0);
    end
    ne = expq.size(); pt = 0;
    for (int unsigned i = 0; i < ne; i++) begin
      n_cmp++;
      if (rxq.size() == 0) begin n_bad++; $display("FAIL wrap_rx: got no byte %0d want one", i); break; end
      r = rxq.pop_front(); e = expq.pop_front();
      if (i == 256 * 6 + 1) wseq = r.data;
      if (r.id != e.id || r.data !== e.data || r.ok !== 1'b1 || (i > 0 && r.t != pt + 40)) begin
        n_bad++; $display("FAIL wrap_byte%0d: got id%0d %h ok=%b gap=%0d want id%0d %h ok=1 gap=40", i, r.id, r.data, r.ok, r.t - pt, e.id, e.data);
      end
      pt = r.t;
    end
    n_cmp++; if (wseq !== 8'h00) begin n_bad++; $display("FAIL wrap_seq_byte: got %h want 00", wseq); end
    expq.delete(); rxq.delete();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; mseq = 8'd0;
    rstv = '1; vld = '0; btn = '0; dlt = '0;
    fork
      mon(0, 1);
      mon(1, 1);
      mon(2, 2);
    join_none
    test_reset();
    test_basic();
    test_csum_noseq();
    test_axes_stop2();
    test_back_to_back();
    test_reset_mid();
    test_seq_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
